mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - MEM pipeline stage: runs loads/stores on the data bus, feeds mem_wreg_* into the MEM/WB register.
// - Non-memory ops pass ex_* straight through to mem_wreg_* (combinational).
// - Memory ops hold stallreq_o until the bus responds. Load data is byte-lane extracted and sign/zero extended.
// PARAMETERS
// - DBUS_TIMEOUT  256  max cycles in S_DATA waiting for dbus_rvalid_i before bus_err_o fires (min 2)
// PORTS
// clk              in   1   clock; all state updates on the rising edge
// rst              in   1   asynchronous, active-high reset
// ex_wreg_i        in   1   write-back enable from EX/MEM
// ex_wreg_addr_i   in   5   destination register
// ex_wreg_data_i   in   32  ALU result (non-load write-back value)
// ex_memop_i       in   4   0 NONE,1 LB,2 LH,3 LW,4 LBU,5 LHU,9 SB,A SH,B SW; any other code = NONE
// ex_mem_addr_i    in   32  effective byte address
// ex_mem_wdata_i   in   32  store data (rs2)
// stalled_i        in   1   ctrl stall of MEM/WB; 1 = downstream will not capture this cycle
// flush_i          in   1   ctrl flush; kills the op currently in MEM
// dbus_req_o       out  1   bus request; held until dbus_gnt_i
// dbus_we_o        out  1   1 = store
// dbus_addr_o      out  32  word-aligned address {addr[31:2],2'b00}
// dbus_wdata_o     out  32  lane-replicated store data
// dbus_be_o        out  4   byte enables
// dbus_gnt_i       in   1   request accepted this cycle
// dbus_rvalid_i    in   1   response (load data / store ack) valid
// dbus_rdata_i     in   32  load data word
// mem_wreg_o       out  1   to MEM/WB: write enable
// mem_wreg_addr_o  out  5   to MEM/WB: destination register
// mem_wreg_data_o  out  32  to MEM/WB: write-back data
// stallreq_o       out  1   to ctrl: stall IF..MEM
// bus_err_o        out  1   one-cycle pulse on timeout
// misalign_o       out  1   one-cycle pulse on misaligned access (MEM_MISALIGN_TRAP_EN only)
// BEHAVIOUR
// - Reset: state S_IDLE, buffers and counter cleared. While rst is high every output is 0.
// - FSM S_IDLE/S_ADDR/S_DATA/S_HOLD. Registered request fields (we, addr, wdata, be, memop) drive the bus.
// - S_IDLE + valid memop + !flush_i: capture request, stallreq_o=1, go S_ADDR. Otherwise pass through, stallreq_o=0.
// - S_ADDR: dbus_req_o=1, stallreq_o=1. gnt -> S_DATA. Request fields stay constant until gnt.
// - S_DATA: stallreq_o=1 until rvalid. On rvalid: load data extended, or store ack.
//   - stalled_i=0: stallreq_o=0, present result to MEM/WB this cycle, go S_IDLE.
//   - stalled_i=1: latch result into hold buffer, go S_HOLD.
// - S_HOLD: stallreq_o=0, outputs driven from hold buffer. First cycle with stalled_i=0 -> S_IDLE.
// - Latency: a load with gnt on first request cycle and rvalid next cycle stalls 2 cycles and retires on the 3rd.
// - Result: loads give mem_wreg_o=ex_wreg_i and the extended data. Stores give mem_wreg_o=0.
// - Store lanes: SB wdata={4{b}}, be=4'b0001<<addr[1:0]. SH wdata={2{h}}, be=addr[1]?4'b1100:4'b0011. SW be=4'hF.
// - Load lanes: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]. LB/LH sign-extend, LBU/LHU zero-extend.
// - flush_i in S_ADDR/S_DATA: set discard flag. Bus transaction still completes (req held until gnt).
//   Response is dropped: mem_wreg_o=0, then S_IDLE. flush_i in S_HOLD: clear the buffer's wreg, go S_IDLE.
// - Timeout: counter counts S_DATA cycles. At DBUS_TIMEOUT with no rvalid: bus_err_o pulses, result = wreg 0, data 0.
//   Then normal S_DATA exit rules apply. A late rvalid afterwards is ignored.
// - Simultaneous rvalid and flush_i in S_DATA: discard wins.
// - Reset mid-transaction: abort immediately. dbus_req_o drops asynchronously.
// CONFIGURATION
// - MEM_MISALIGN_TRAP_EN defined: misaligned access is one of:
//   - LH/LHU/SH with addr[0]=1
//   - LW/SW with addr[1:0]!=0
//   Effect: no bus request, misalign_o pulses in S_IDLE, mem_wreg_o=0, stallreq_o=0.
// - Not defined: misalign_o tied 0. Low address bits are ignored for lane selection (half uses addr[1], word uses lane 0).
// TESTING
// - ALU op ex_wreg_data_i=0x1234, memop=0 -> same cycle mem_wreg_data_o=0x1234, stallreq_o=0, no dbus_req_o.
// - LB addr 0x103, rdata 0x80FFFFFF, gnt immediate, rvalid next -> data 0xFFFFFF80, stallreq_o high 2 cycles.
// - SH addr 0x202 wdata 0xABCD -> dbus_be_o=4'b1100, dbus_wdata_o=0xABCDABCD, dbus_addr_o=0x200, mem_wreg_o=0.
// - LHU addr 0x0, gnt after 3 cycles, rvalid with stalled_i=1 for 2 cycles -> S_HOLD, data 0x0000xxxx held stable.
// - LW with no rvalid, DBUS_TIMEOUT=4 -> bus_err_o pulse after 4 S_DATA cycles, mem_wreg_o=0, return S_IDLE.
// - flush_i during S_ADDR of LW -> req held to gnt, rvalid discarded, mem_wreg_o=0. With trap enabled: LW addr 0x2 -> misalign_o=1, no req.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: drives the data bus for loads/stores and feeds MEM/WB.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int unsigned DBUS_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wreg_addr_i,
  input  logic [31:0] ex_wreg_data_i,
  input  logic [3:0]  ex_memop_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_mem_wdata_i,
  input  logic        stalled_i,
  input  logic        flush_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        mem_wreg_o,
  output logic [4:0]  mem_wreg_addr_o,
  output logic [31:0] mem_wreg_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        misalign_o
);
  localparam int unsigned CNT_W = $clog2(DBUS_TIMEOUT);
  localparam logic [3:0] OP_LB = 4'h1, OP_LH = 4'h2, OP_LW = 4'h3, OP_LBU = 4'h4,
                         OP_LHU = 4'h5, OP_SB = 4'h9, OP_SH = 4'hA, OP_SW = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic               req_we_q, req_we_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [31:0]        req_wdata_q, req_wdata_d;
  logic [3:0]         req_be_q, req_be_d;
  logic [3:0]         req_memop_q, req_memop_d;
  logic               req_wreg_q, req_wreg_d;
  logic [4:0]         req_wreg_addr_q, req_wreg_addr_d;
  logic               discard_q, discard_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_wreg_q, hold_wreg_d;
  logic [4:0]         hold_wreg_addr_q, hold_wreg_addr_d;
  logic [31:0]        hold_data_q, hold_data_d;

  logic        op_valid_c, misalign_c, start_c, timeout_c, resp_c, drop_c, resp_wreg_c;
  logic [31:0] st_wdata_c, resp_data_c;
  logic [3:0]  st_be_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    case (ex_memop_i)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_valid_c = 1'b1;
      default: op_valid_c = 1'b0;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    case (ex_memop_i)
      OP_LH, OP_LHU, OP_SH: misalign_c = ex_mem_addr_i[0];
      OP_LW, OP_SW:         misalign_c = |ex_mem_addr_i[1:0];
      default:              misalign_c = 1'b0;
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane replication and byte enables
  always_comb begin
    st_wdata_c = ex_mem_wdata_i;
    st_be_c    = 4'hF;
    case (ex_memop_i)
      OP_SB: begin
        st_wdata_c = {4{ex_mem_wdata_i[7:0]}};
        st_be_c    = 4'b0001 << ex_mem_addr_i[1:0];
      end
      OP_SH: begin
        st_wdata_c = {2{ex_mem_wdata_i[15:0]}};
        st_be_c    = ex_mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension; a timeout yields zero
  assign byte_c = dbus_rdata_i[{req_addr_q[1:0], 3'b000} +: 8];
  assign half_c = dbus_rdata_i[{req_addr_q[1], 4'b0000} +: 16];

  always_comb begin
    resp_data_c = 32'h0;
    if (!timeout_c) begin
      case (req_memop_q)
        OP_LB:   resp_data_c = {{24{byte_c[7]}}, byte_c};
        OP_LH:   resp_data_c = {{16{half_c[15]}}, half_c};
        OP_LW:   resp_data_c = dbus_rdata_i;
        OP_LBU:  resp_data_c = {24'h0, byte_c};
        OP_LHU:  resp_data_c = {16'h0, half_c};
        default: resp_data_c = 32'h0;
      endcase
    end
  end

  assign start_c     = (state_q == S_IDLE) && op_valid_c && !flush_i && !misalign_c;
  assign timeout_c   = (state_q == S_DATA) && !dbus_rvalid_i && (cnt_q == CNT_W'(DBUS_TIMEOUT - 1));
  assign resp_c      = (state_q == S_DATA) && (dbus_rvalid_i || timeout_c);
  assign drop_c      = discard_q || flush_i;
  assign resp_wreg_c = req_wreg_q && !req_we_q && !timeout_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      req_we_q         <= 1'b0;
      req_addr_q       <= 32'h0;
      req_wdata_q      <= 32'h0;
      req_be_q         <= 4'h0;
      req_memop_q      <= 4'h0;
      req_wreg_q       <= 1'b0;
      req_wreg_addr_q  <= 5'h0;
      discard_q        <= 1'b0;
      cnt_q            <= '0;
      hold_wreg_q      <= 1'b0;
      hold_wreg_addr_q <= 5'h0;
      hold_data_q      <= 32'h0;
    end else begin
      state_q          <= state_d;
      req_we_q         <= req_we_d;
      req_addr_q       <= req_addr_d;
      req_wdata_q      <= req_wdata_d;
      req_be_q         <= req_be_d;
      req_memop_q      <= req_memop_d;
      req_wreg_q       <= req_wreg_d;
      req_wreg_addr_q  <= req_wreg_addr_d;
      discard_q        <= discard_d;
      cnt_q            <= cnt_d;
      hold_wreg_q      <= hold_wreg_d;
      hold_wreg_addr_q <= hold_wreg_addr_d;
      hold_data_q      <= hold_data_d;
    end
  end

  // Next state and request/hold buffer updates
  always_comb begin
    state_d          = state_q;
    req_we_d         = req_we_q;
    req_addr_d       = req_addr_q;
    req_wdata_d      = req_wdata_q;
    req_be_d         = req_be_q;
    req_memop_d      = req_memop_q;
    req_wreg_d       = req_wreg_q;
    req_wreg_addr_d  = req_wreg_addr_q;
    discard_d        = discard_q;
    cnt_d            = cnt_q;
    hold_wreg_d      = hold_wreg_q;
    hold_wreg_addr_d = hold_wreg_addr_q;
    hold_data_d      = hold_data_q;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          state_d         = S_ADDR;
          req_we_d        = ex_memop_i[3];
          req_addr_d      = ex_mem_addr_i;
          req_wdata_d     = st_wdata_c;
          req_be_d        = st_be_c;
          req_memop_d     = ex_memop_i;
          req_wreg_d      = ex_wreg_i;
          req_wreg_addr_d = ex_wreg_addr_i;
          discard_d       = 1'b0;
        end
      end
      S_ADDR: begin
        if (flush_i) discard_d = 1'b1;
        if (dbus_gnt_i) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (flush_i) discard_d = 1'b1;
        if (resp_c) begin
          if (drop_c || !stalled_i) begin
            state_d = S_IDLE;
          end else begin
            state_d          = S_HOLD;
            hold_wreg_d      = resp_wreg_c;
            hold_wreg_addr_d = req_wreg_addr_q;
            hold_data_d      = resp_data_c;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          hold_wreg_d = 1'b0;
          state_d     = S_IDLE;
        end else if (!stalled_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; everything forced low while reset is asserted
  always_comb begin
    dbus_req_o      = 1'b0;
    dbus_we_o       = 1'b0;
    dbus_addr_o     = 32'h0;
    dbus_wdata_o    = 32'h0;
    dbus_be_o       = 4'h0;
    mem_wreg_o      = 1'b0;
    mem_wreg_addr_o = 5'h0;
    mem_wreg_data_o = 32'h0;
    stallreq_o      = 1'b0;
    bus_err_o       = 1'b0;
    misalign_o      = 1'b0;
    if (!rst) begin
      dbus_we_o    = req_we_q;
      dbus_addr_o  = {req_addr_q[31:2], 2'b00};
      dbus_wdata_o = req_wdata_q;
      dbus_be_o    = req_be_q;
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            stallreq_o = 1'b1;
          end else if (op_valid_c && !flush_i && misalign_c) begin
            misalign_o = 1'b1;
          end else begin
            mem_wreg_o      = ex_wreg_i && !flush_i;
            mem_wreg_addr_o = ex_wreg_addr_i;
            mem_wreg_data_o = ex_wreg_data_i;
          end
        end
        S_ADDR: begin
          dbus_req_o = 1'b1;
          stallreq_o = 1'b1;
        end
        S_DATA: begin
          stallreq_o = !resp_c;
          bus_err_o  = timeout_c;
          if (resp_c && !drop_c) begin
            mem_wreg_o      = resp_wreg_c;
            mem_wreg_addr_o = req_wreg_addr_q;
            mem_wreg_data_o = resp_data_c;
          end
        end
        S_HOLD: begin
          mem_wreg_o      = hold_wreg_q && !flush_i;
          mem_wreg_addr_o = hold_wreg_addr_q;
          mem_wreg_data_o = hold_data_q;
        end
        default: ;
      endcase
    end
  end
endmodule
